// File: rtl/ula_arbiter_if.sv
// Request/grant/result bundle between two requesters plus one consumer and the shared ULA arbiter.
// The master side drives requests and ack; the slave side (the arbiter) drives grants and results.
interface ula_arbiter_if #(
  parameter int W = 4
);
  logic           req0;
  logic [W-1:0]   a0;
  logic [W-1:0]   b0;
  logic [1:0]     op0;
  logic           req1;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic [1:0]     op1;
  logic           gnt0;
  logic           gnt1;
  logic           busy;
  logic           valid;
  logic           ack;
  logic           owner;
  logic [2*W-1:0] result;
  logic [3:0]     result2;
  logic           dz;

  modport master (
    output req0, a0, b0, op0, req1, a1, b1, op1, ack,
    input  gnt0, gnt1, busy, valid, owner, result, result2, dz
  );

  modport slave (
    input  req0, a0, b0, op0, req1, a1, b1, op1, ack,
    output gnt0, gnt1, busy, valid, owner, result, result2, dz
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin shared 4-op ULA: single-cycle sum/sub/mult, W-cycle restoring divide,
// result held with a range class until the consumer acks it. All outputs registered.
module ula_arbiter #(
  parameter int W      = 4,
  parameter int SUM_OP = 0,
  parameter int SUB_OP = 1,
  parameter int MUL_OP = 2,
  parameter int DIV_OP = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  ula_arbiter_if.slave   bus
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           w_take0;
  logic           w_take1;

  logic           r_last;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [1:0]     r_op;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic [2*W-1:0] r_calc_res;
  logic [3:0]     r_calc_r2;
  logic           r_calc_dz;

  logic           r_gnt0;
  logic           r_gnt1;
  logic           r_busy;
  logic           r_valid;
  logic           r_owner;
  logic [2*W-1:0] r_result;
  logic [3:0]     r_result2;
  logic           r_dz;

  logic [2*W-1:0] w_a_ext;
  logic [2*W-1:0] w_b_ext;
  logic [2*W-1:0] w_sum;
  logic [2*W-1:0] w_mul;
  logic [2*W-1:0] w_diff;
  logic           w_swap;
  logic [2*W-1:0] w_class_in;
  logic [8:0]     w_gt;
  logic [3:0]     w_class;
  logic           w_is_div;
  logic           w_div_zero;
  logic [W:0]     w_shift;
  logic           w_ge;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_quo_next;

  assign w_a_ext    = {{W{1'b0}}, r_a};
  assign w_b_ext    = {{W{1'b0}}, r_b};
  assign w_sum      = w_a_ext + w_b_ext;
  assign w_mul      = w_a_ext * w_b_ext;
  assign w_swap     = (r_b > r_a);
  assign w_diff     = w_swap ? (w_b_ext - w_a_ext) : (w_a_ext - w_b_ext);
  assign w_class_in = (r_op == 2'(MUL_OP)) ? w_mul : w_sum;
  assign w_is_div   = (r_op == 2'(DIV_OP));
  assign w_div_zero = (r_b == '0);

  // Range class: count of thresholds 10,20,...,90 strictly exceeded.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_thr
      assign w_gt[gi] = (w_class_in > (2*W)'(10 * (gi + 1)));
    end
  endgenerate

  always_comb begin
    w_class = 4'd0;
    for (int i = 0; i < 9; i++) begin
      w_class = w_class + 4'(w_gt[i]);
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_rem_next = w_ge ? W'(w_shift - {1'b0, r_b}) : w_shift[W-1:0];
  assign w_quo_next = {r_quo[W-2:0], w_ge};

  always_comb begin
    w_state_next = r_state;
    w_take0      = 1'b0;
    w_take1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_take0 = bus.req0 && (!bus.req1 || r_last);
        w_take1 = bus.req1 && (!bus.req0 || !r_last);
        if (w_take0 || w_take1) begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!w_is_div || w_div_zero || (r_cnt == '0)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (r_valid && bus.ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_calc_res <= '0;
      r_calc_r2  <= '0;
      r_calc_dz  <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_owner    <= 1'b0;
      r_result   <= '0;
      r_result2  <= '0;
      r_dz       <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_busy <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_rem <= '0;
          r_cnt <= CNT_W'(W - 1);
          if (w_take0) begin
            r_a     <= bus.a0;
            r_b     <= bus.b0;
            r_op    <= bus.op0;
            r_quo   <= bus.a0;
            r_owner <= 1'b0;
            r_last  <= 1'b0;
            r_gnt0  <= 1'b1;
          end else if (w_take1) begin
            r_a     <= bus.a1;
            r_b     <= bus.b1;
            r_op    <= bus.op1;
            r_quo   <= bus.a1;
            r_owner <= 1'b1;
            r_last  <= 1'b1;
            r_gnt1  <= 1'b1;
          end
        end
        S_EXEC: begin
          r_calc_dz <= 1'b0;
          if (r_op == 2'(SUM_OP)) begin
            r_calc_res <= w_sum;
            r_calc_r2  <= w_class;
          end else if (r_op == 2'(SUB_OP)) begin
            r_calc_res <= w_diff;
            r_calc_r2  <= w_swap ? 4'hF : 4'h0;
          end else if (r_op == 2'(MUL_OP)) begin
            r_calc_res <= w_mul;
            r_calc_r2  <= w_class;
          end else if (w_div_zero) begin
            r_calc_res <= {{W{1'b0}}, {W{1'b1}}};
            r_calc_r2  <= 4'(r_a);
            r_calc_dz  <= 1'b1;
          end else begin
            // Staging is refreshed every step; the value from the cnt==0 step is the one kept.
            r_quo      <= w_quo_next;
            r_rem      <= w_rem_next;
            r_cnt      <= r_cnt - CNT_W'(1);
            r_calc_res <= {{W{1'b0}}, w_quo_next};
            r_calc_r2  <= 4'(w_rem_next);
          end
        end
        S_DONE: begin
          if (!r_valid) begin
            r_result  <= r_calc_res;
            r_result2 <= r_calc_r2;
            r_dz      <= r_calc_dz;
            r_valid   <= 1'b1;
          end else if (bus.ack) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.busy    = r_busy;
  assign bus.valid   = r_valid;
  assign bus.owner   = r_owner;
  assign bus.result  = r_result;
  assign bus.result2 = r_result2;
  assign bus.dz      = r_dz;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed plus randomized jobs on the shared ULA arbiter, checked against an arithmetic
// reference model of the requester/consumer protocol.
module tb_ula_arbiter;

  localparam int W = 4;
  localparam logic [1:0] SUM = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] MUL = 2'd2;
  localparam logic [1:0] DIV = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic m_last = 1'b1;

  ula_arbiter_if #(.W(W)) bus();

  ula_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_class(input int v);
    int c;
    c = (v <= 0) ? 0 : (v - 1) / 10;
    return (c > 9) ? 9 : c;
  endfunction

  task automatic ref_model(input int a, input int b, input logic [1:0] op,
                           output int res, output int r2, output int dz, output int lat);
    dz  = 0;
    lat = 2;
    res = 0;
    r2  = 0;
    case (op)
      SUM: begin res = a + b; r2 = ref_class(res); end
      SUB: begin
        if (a >= b) begin res = a - b; r2 = 0; end
        else begin res = b - a; r2 = 15; end
      end
      MUL: begin res = a * b; r2 = ref_class(res); end
      default: begin
        if (b == 0) begin res = (1 << W) - 1; r2 = a; dz = 1; end
        else begin res = a / b; r2 = a % b; lat = W + 1; end
      end
    endcase
  endtask

  task automatic do_job(input logic q0, input logic q1,
                        input logic [3:0] x0, input logic [3:0] y0, input logic [1:0] p0,
                        input logic [3:0] x1, input logic [3:0] y1, input logic [1:0] p1,
                        input int hold, input logic keep, input logic raise1);
    logic w;
    int n;
    int ea, eb;
    logic [1:0] eo;
    int eres, er2, edz, elat;
    w = (q0 && q1) ? ~m_last : q1;
    bus.a0 = x0; bus.b0 = y0; bus.op0 = p0;
    bus.a1 = x1; bus.b1 = y1; bus.op1 = p1;
    bus.req0 = q0; bus.req1 = q1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.gnt0 || bus.gnt1) && n < 10);
    chk("grant_wait", n, 1);
    chk("gnt0", bus.gnt0, !w);
    chk("gnt1", bus.gnt1, w);
    chk("busy_at_grant", bus.busy, 1);
    m_last = w;
    if (!keep) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    ea = w ? int'(x1) : int'(x0);
    eb = w ? int'(y1) : int'(y0);
    eo = w ? p1 : p0;
    ref_model(ea, eb, eo, eres, er2, edz, elat);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (raise1 && n == 1) bus.req1 = 1'b1;
      chk("no_gnt_while_busy", bus.gnt0 | bus.gnt1, 0);
    end while (!bus.valid && n < 20);
    chk("latency", n, elat);
    chk("result", bus.result, eres);
    chk("result2", bus.result2, er2);
    chk("dz", bus.dz, edz);
    chk("owner", bus.owner, w);
    chk("busy_done", bus.busy, 1);
    $display("job owner=%0d op=%0d a=%0d b=%0d result=%0d result2=%0d dz=%0d latency=%0d",
             w, eo, ea, eb, bus.result, bus.result2, bus.dz, n);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", bus.valid, 1);
      chk("hold_result", bus.result, eres);
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("ack_valid", bus.valid, 0);
    chk("ack_busy", bus.busy, 0);
    chk("ack_gnt", bus.gnt0 | bus.gnt1, 0);
  endtask

  initial begin
    logic q0, q1;
    logic [3:0] x0, y0, x1, y1;
    logic [1:0] p0, p1;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.op0 = SUM;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.op1 = SUM;
    bus.ack  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    chk("rst_gnt", bus.gnt0 | bus.gnt1, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result2", bus.result2, 0);
    chk("rst_dz", bus.dz, 0);

    do_job(1'b1, 1'b0, 4'd7, 4'd9, SUM, 4'd0, 4'd0, SUM, 5, 1'b0, 1'b0);
    do_job(1'b0, 1'b1, 4'd0, 4'd0, SUM, 4'd3, 4'd12, SUB, 1, 1'b0, 1'b0);
    do_job(1'b0, 1'b1, 4'd0, 4'd0, SUM, 4'd12, 4'd3, SUB, 1, 1'b0, 1'b0);
    do_job(1'b1, 1'b0, 4'd13, 4'd4, DIV, 4'd0, 4'd0, SUM, 1, 1'b0, 1'b0);
    do_job(1'b1, 1'b0, 4'd13, 4'd0, DIV, 4'd0, 4'd0, SUM, 1, 1'b0, 1'b0);

    // ack while idle must not disturb anything
    bus.ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_busy", bus.busy, 0);
      chk("idle_ack_valid", bus.valid, 0);
      chk("idle_ack_gnt", bus.gnt0 | bus.gnt1, 0);
    end
    bus.ack = 1'b0;

    // req1 raised mid-EXEC waits until the current result is acked
    do_job(1'b1, 1'b0, 4'd9, 4'd2, DIV, 4'd5, 4'd6, MUL, 2, 1'b0, 1'b1);
    do_job(1'b0, 1'b1, 4'd9, 4'd2, DIV, 4'd5, 4'd6, MUL, 0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      if (!q0 && !q1) q0 = 1'b1;
      x0 = 4'($urandom_range(0, 15)); y0 = 4'($urandom_range(0, 15)); p0 = 2'($urandom_range(0, 3));
      x1 = 4'($urandom_range(0, 15)); y1 = 4'($urandom_range(0, 15)); p1 = 2'($urandom_range(0, 3));
      do_job(q0, q1, x0, y0, p0, x1, y1, p1, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    // Abort a divide in its second EXEC cycle
    bus.a0 = 4'd13; bus.b0 = 4'd4; bus.op0 = DIV; bus.req0 = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.gnt0 && n < 10);
      chk("abort_gnt0", bus.gnt0, 1);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.valid, 0);
    chk("abort_gnt", bus.gnt0 | bus.gnt1, 0);
    chk("abort_owner", bus.owner, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_result2", bus.result2, 0);
    chk("abort_dz", bus.dz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_abort_valid", bus.valid, 0);
      chk("post_abort_busy", bus.busy, 0);
    end

    // Both requesting continuously: grants alternate starting with requester 0
    for (int j = 0; j < 4; j++) begin
      do_job(1'b1, 1'b1, 4'd15, 4'd15, MUL, 4'd15, 4'd15, MUL, 1, 1'b1, 1'b0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
